// File: rtl/exec_alu.sv
// RV32I execute-stage integer ALU with one registered output stage.
// A result is captured on each edge where in_valid is high and appears on res one cycle later.
module exec_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [3:0]      alu_code,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] res,
  output logic            out_valid
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_LS   = 4'd3,
    ALU_RSA  = 4'd4,
    ALU_RSL  = 4'd5,
    ALU_CMP  = 4'd6,
    ALU_CMPU = 4'd7,
    ALU_AND  = 4'd8,
    ALU_OR   = 4'd9,
    ALU_XOR  = 4'd10
  } alu_code_e;

  // Handshake: valid-only, no ready. in_valid qualifies alu_code/op1/op2 in the
  // same cycle; out_valid marks res as fresh exactly one cycle later.
  logic [XLEN-1:0] res_q, res_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] f_w;
  logic [SHW-1:0]  shamt_w;
  logic            lt_s_w, lt_u_w, eq_w;

  assign shamt_w = op2[SHW-1:0];
  assign lt_s_w  = $signed(op1) < $signed(op2);
  assign lt_u_w  = op1 < op2;
  assign eq_w    = op1 == op2;

  always_comb begin
    f_w = '0;
    case (alu_code)
      ALU_ADD:  f_w = op1 + op2;
      ALU_SUB:  f_w = op1 - op2;
      ALU_LS:   f_w = op1 << shamt_w;
      ALU_RSA:  f_w = $unsigned($signed(op1) >>> shamt_w);
      ALU_RSL:  f_w = op1 >> shamt_w;
      ALU_CMP:  f_w = {{(XLEN-2){1'b0}}, lt_s_w, eq_w};
      ALU_CMPU: f_w = {{(XLEN-2){1'b0}}, lt_u_w, eq_w};
      ALU_AND:  f_w = op1 & op2;
      ALU_OR:   f_w = op1 | op2;
      ALU_XOR:  f_w = op1 ^ op2;
      default:  f_w = '0;
    endcase
  end

  // Holding res via an explicit if keeps an unknown alu_code out of res while idle.
  always_comb begin
    res_d   = res_q;
    valid_d = in_valid;
    if (in_valid) begin
      res_d = f_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign res       = res_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_exec_alu.sv
// Directed bench for exec_alu: hand-computed vectors, hold, reset and back-to-back sequences.
module tb_exec_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [3:0]   alu_code;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [W-1:0] res;
  logic         out_valid;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  exec_alu #(.XLEN(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .alu_code  (alu_code),
    .op1       (op1),
    .op2       (op2),
    .res       (res),
    .out_valid (out_valid)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of sequence");
    $fatal(1, "watchdog");
  end

  // Driver: apply inputs just after an edge, then advance to 1ns past the next edge.
  task automatic step(input logic v, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = v;
    alu_code = c;
    op1      = a;
    op2      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [W-1:0] exp, input logic exp_v);
    chk({tag, ".res"}, res, exp);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_v});
  endtask

  // Scoreboard: issue an op and queue its expected result; pop on the following edge.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp);
    exp_q.push_back(exp);
    step(1'b1, c, a, b);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      chk_res("b2b", exp_q.pop_front(), 1'b1);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    alu_code = 4'd0;
    op1      = '0;
    op2      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_res("reset", 32'd0, 1'b0);
    rst_n = 1'b1;

    // Arithmetic
    step(1'b1, 4'd1, 32'd123, 32'd7);
    chk_res("add", 32'd130, 1'b1);
    step(1'b0, 4'd2, 32'd1, 32'd1);
    chk_res("hold1", 32'd130, 1'b0);
    step(1'b0, 4'bxxxx, 32'd9, 32'd9);
    chk_res("hold2_xcode", 32'd130, 1'b0);
    step(1'b0, 4'd8, 32'hFFFF_FFFF, 32'd0);
    chk_res("hold3", 32'd130, 1'b0);
    step(1'b1, 4'd2, 32'd123, 32'd125);
    chk_res("sub_neg", 32'hFFFF_FFFE, 1'b1);
    step(1'b1, 4'd1, 32'hFFFF_FFFF, 32'd1);
    chk_res("add_wrap", 32'd0, 1'b1);

    // Shifts
    step(1'b1, 4'd3, 32'd3, 32'd2);
    chk_res("ls", 32'd12, 1'b1);
    step(1'b1, 4'd3, 32'd3, 32'h22);
    chk_res("ls_hi_ignored", 32'd12, 1'b1);
    step(1'b1, 4'd4, 32'hFFFF_FFF0, 32'd2);
    chk_res("rsa", 32'hFFFF_FFFC, 1'b1);
    step(1'b1, 4'd5, 32'hFFFF_FFFF, 32'd2);
    chk_res("rsl", 32'h3FFF_FFFF, 1'b1);
    step(1'b1, 4'd4, 32'h8000_1234, 32'd0);
    chk_res("rsa_zero", 32'h8000_1234, 1'b1);
    step(1'b1, 4'd3, 32'd1, 32'd31);
    chk_res("ls_31", 32'h8000_0000, 1'b1);

    // Compares
    step(1'b1, 4'd6, 32'hFFFF_FFFE, 32'd2);
    chk_res("cmp_lt", 32'd2, 1'b1);
    step(1'b1, 4'd7, 32'hFFFF_FFFE, 32'd2);
    chk_res("cmpu_ge", 32'd0, 1'b1);
    step(1'b1, 4'd6, 32'd5, 32'd5);
    chk_res("cmp_eq", 32'd1, 1'b1);
    step(1'b1, 4'd7, 32'd5, 32'd5);
    chk_res("cmpu_eq", 32'd1, 1'b1);
    step(1'b1, 4'd7, 32'd2, 32'hFFFF_FFFE);
    chk_res("cmpu_lt", 32'd2, 1'b1);

    // Logic, NONE and reserved
    step(1'b1, 4'd8, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    chk_res("and", 32'h00F0_000F, 1'b1);
    step(1'b1, 4'd9, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    chk_res("or", 32'hFFF0_0FFF, 1'b1);
    step(1'b1, 4'd10, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    chk_res("xor", 32'hFF00_0FF0, 1'b1);
    step(1'b1, 4'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    chk_res("none", 32'd0, 1'b1);
    step(1'b1, 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_res("reserved13", 32'd0, 1'b1);

    // Back-to-back, one result per cycle, in order
    issue(4'd1, 32'd1, 32'd2, 32'd3);
    issue(4'd2, 32'd10, 32'd3, 32'd7);
    issue(4'd10, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555);
    issue(4'd5, 32'h8000_0000, 32'd31, 32'd1);
    issue(4'd3, 32'h0000_00FF, 32'd8, 32'h0000_FF00);

    // Asynchronous reset between edges
    step(1'b1, 4'd1, 32'd40, 32'd2);
    chk_res("pre_reset", 32'd42, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_res("async_reset", 32'd0, 1'b0);
    @(posedge clk);
    #1;
    chk_res("reset_held", 32'd0, 1'b0);
    #2;
    rst_n = 1'b1;
    step(1'b1, 4'd1, 32'd123, 32'd7);
    chk_res("post_reset", 32'd130, 1'b1);
    step(1'b0, 4'd0, 32'd0, 32'd0);
    chk_res("post_idle", 32'd130, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
